// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer: captures one packed M_SIZE x M_SIZE result matrix
// and replays it one element per beat, row-major, on a valid/ready stream
// with row/column tags, a last marker and an end-of-frame pulse.
// Optional build macro MMAC_STREAM_PARITY_EN adds out_parity and
// load_parity_err_inject.
module matrix_result_streamer #(
    parameter int unsigned M_SIZE    = 4,
    parameter int unsigned VAR_WIDTH = 8,
    parameter int unsigned IDX_W     = $clog2(M_SIZE)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                clear,
    input  logic                                load_valid,
    output logic                                load_ready,
    input  logic [M_SIZE*M_SIZE*VAR_WIDTH-1:0]  result_in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [VAR_WIDTH-1:0]                out_data,
    output logic [IDX_W-1:0]                    out_row,
    output logic [IDX_W-1:0]                    out_col,
    output logic                                out_last,
    output logic                                frame_done,
    output logic                                overrun
`ifdef MMAC_STREAM_PARITY_EN
    ,
    output logic                                out_parity,
    input  logic                                load_parity_err_inject
`endif
);

    localparam int unsigned NUM_ELEM = M_SIZE * M_SIZE;
    localparam int unsigned MAT_W    = NUM_ELEM * VAR_WIDTH;
    localparam int unsigned CNT_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       index_q, index_d;
    logic [MAT_W-1:0]       cap_q, cap_d;
    logic                   load_ready_q, load_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [VAR_WIDTH-1:0]   out_data_q, out_data_d;
    logic [IDX_W-1:0]       out_row_q, out_row_d;
    logic [IDX_W-1:0]       out_col_q, out_col_d;
    logic                   out_last_q, out_last_d;
    logic                   frame_done_q, frame_done_d;
    logic                   overrun_q, overrun_d;

    logic                   load_fire_c;
    logic                   beat_fire_c;
    logic                   last_now_c;
    logic                   col_wrap_c;
    logic [CNT_W-1:0]       idx_nxt_c;
    logic [IDX_W-1:0]       col_nxt_c;
    logic [IDX_W-1:0]       row_nxt_c;
    logic [VAR_WIDTH-1:0]   data_nxt_c;
    logic [VAR_WIDTH-1:0]   elem0_c;

    // Element idx of a packed matrix; element 0 sits in the MSBs.
    function automatic logic [VAR_WIDTH-1:0] pick_elem(input logic [MAT_W-1:0] mat,
                                                       input logic [CNT_W-1:0] idx);
        logic [MAT_W-1:0] shifted;
        shifted = mat << (32'(idx) * VAR_WIDTH);
        return shifted[MAT_W-1 -: VAR_WIDTH];
    endfunction

    // Handshake qualifiers and the coordinates of the following beat.
    assign load_fire_c = !clear && (state_q == ST_IDLE) && load_valid;
    assign beat_fire_c = !clear && (state_q == ST_STREAM) && out_ready;
    assign last_now_c  = (index_q == CNT_W'(NUM_ELEM - 1));
    assign idx_nxt_c   = index_q + CNT_W'(1);
    assign col_wrap_c  = (out_col_q == IDX_W'(M_SIZE - 1));
    assign col_nxt_c   = col_wrap_c ? '0 : out_col_q + IDX_W'(1);
    assign row_nxt_c   = col_wrap_c ? out_row_q + IDX_W'(1) : out_row_q;
    assign data_nxt_c  = pick_elem(cap_q, idx_nxt_c);
    assign elem0_c     = pick_elem(result_in, '0);

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        cap_d        = cap_q;
        load_ready_d = load_ready_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        out_last_d   = out_last_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;

        if (clear) begin
            state_d      = ST_IDLE;
            index_d      = '0;
            load_ready_d = 1'b1;
            out_valid_d  = 1'b0;
            out_row_d    = '0;
            out_col_d    = '0;
            out_last_d   = 1'b0;
            overrun_d    = 1'b0;
        end else begin
            if (load_valid && !load_ready_q) begin
                overrun_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (load_fire_c) begin
                        state_d      = ST_STREAM;
                        cap_d        = result_in;
                        index_d      = '0;
                        load_ready_d = 1'b0;
                        out_valid_d  = 1'b1;
                        out_data_d   = elem0_c;
                        out_row_d    = '0;
                        out_col_d    = '0;
                        out_last_d   = (NUM_ELEM == 1);
                    end
                end
                ST_STREAM: begin
                    if (beat_fire_c) begin
                        if (last_now_c) begin
                            state_d      = ST_IDLE;
                            index_d      = '0;
                            load_ready_d = 1'b1;
                            out_valid_d  = 1'b0;
                            out_row_d    = '0;
                            out_col_d    = '0;
                            out_last_d   = 1'b0;
                            frame_done_d = 1'b1;
                        end else begin
                            index_d    = idx_nxt_c;
                            out_data_d = data_nxt_c;
                            out_row_d  = row_nxt_c;
                            out_col_d  = col_nxt_c;
                            out_last_d = (idx_nxt_c == CNT_W'(NUM_ELEM - 1));
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            cap_q        <= '0;
            load_ready_q <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            cap_q        <= cap_d;
            load_ready_q <= load_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign load_ready = load_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

`ifdef MMAC_STREAM_PARITY_EN
    logic parity_q, parity_d;

    // Parity follows out_data; the inject flips only the freshly loaded element 0.
    always_comb begin
        parity_d = parity_q;
        if (load_fire_c) begin
            parity_d = (^elem0_c) ^ load_parity_err_inject;
        end else if (beat_fire_c && !last_now_c) begin
            parity_d = ^data_nxt_c;
        end
    end

    // Parity register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed self-checking bench for matrix_result_streamer (M_SIZE=4, VAR_WIDTH=8).
module tb_matrix_result_streamer;

    localparam int unsigned M   = 4;
    localparam int unsigned W   = 8;
    localparam int unsigned N   = M * M;
    localparam int unsigned MW  = N * W;

    logic          clock = 1'b0;
    logic          reset;
    logic          clear;
    logic          load_valid;
    logic          load_ready;
    logic [MW-1:0] result_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    out_row;
    logic [1:0]    out_col;
    logic          out_last;
    logic          frame_done;
    logic          overrun;
`ifdef MMAC_STREAM_PARITY_EN
    logic          out_parity;
    logic          inject;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    matrix_result_streamer #(
        .M_SIZE    (M),
        .VAR_WIDTH (W),
        .IDX_W     (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .result_in  (result_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last),
        .frame_done (frame_done),
        .overrun    (overrun)
`ifdef MMAC_STREAM_PARITY_EN
        ,
        .out_parity             (out_parity),
        .load_parity_err_inject (inject)
`endif
    );

    always #5 clock = ~clock;

    // Matrix whose element e holds base + step*e.
    function automatic logic [MW-1:0] mk_mat(input int base, input int step);
        logic [MW-1:0] m;
        m = '0;
        for (int e = 0; e < int'(N); e++) begin
            m[(int'(N) - 1 - e) * int'(W) +: W] = 8'(base + step * e);
        end
        return m;
    endfunction

    // Expected {valid, load_ready, data, row, col, last, frame_done} for beat b.
    function automatic logic [15:0] exp_beat(input int data, input int b);
        return {1'b1, 1'b0, 8'(data), 2'(b / 4), 2'(b % 4), (b == 15), 1'b0};
    endfunction

    function automatic logic [15:0] obs_beat();
        return {out_valid, load_ready, out_data, out_row, out_col, out_last, frame_done};
    endfunction

    task automatic test_reset();
        reset = 1'b0; clear = 1'b0; load_valid = 1'b0; out_ready = 1'b0; result_in = '0;
`ifdef MMAC_STREAM_PARITY_EN
        inject = 1'b0;
`endif
        repeat (2) @(negedge clock);
        total_cnt++;
        if ({out_valid, out_data, out_row, out_col, out_last, frame_done, overrun} !== 15'd0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {out_valid, out_data, out_row, out_col, out_last, frame_done, overrun});
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clock);
        total_cnt++;
        if ({load_ready, out_valid} !== 2'b10)
            $display("FAIL reset_load_ready: got %b expected 10", {load_ready, out_valid});
        else pass_cnt++;
    endtask

    task automatic test_full_rate();
        logic [MW-1:0] m;
        m = mk_mat(1, 1);
        result_in = m; load_valid = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        load_valid = 1'b0;
        for (int b = 0; b < 16; b++) begin
            total_cnt++;
            if (obs_beat() !== exp_beat(b + 1, b))
                $display("FAIL full_rate_beat%0d: got %h expected %h", b, obs_beat(), exp_beat(b + 1, b));
            else pass_cnt++;
            @(negedge clock);
        end
        total_cnt++;
        if ({frame_done, out_valid, load_ready, out_last} !== 4'b1010)
            $display("FAIL full_rate_end: got %b expected 1010", {frame_done, out_valid, load_ready, out_last});
        else pass_cnt++;
        @(negedge clock);
        total_cnt++;
        if ({frame_done, out_valid} !== 2'b00)
            $display("FAIL full_rate_pulse: got %b expected 00", {frame_done, out_valid});
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int  b;
        int  cyc;
        logic rdy;
        b = 0; cyc = 0;
        result_in = mk_mat(1, 1); load_valid = 1'b1; out_ready = 1'b0;
        @(negedge clock);
        load_valid = 1'b0;
        while (b < 16 && cyc < 100) begin
            total_cnt++;
            if (obs_beat() !== exp_beat(b + 1, b))
                $display("FAIL backpressure_beat%0d_cyc%0d: got %h expected %h",
                         b, cyc, obs_beat(), exp_beat(b + 1, b));
            else pass_cnt++;
            rdy = (cyc % 3 == 0);
            out_ready = rdy;
            @(negedge clock);
            if (rdy) b++;
            cyc++;
        end
        total_cnt++;
        if (b != 16) $display("FAIL backpressure_timeout: got %0d beats expected 16", b);
        else pass_cnt++;
        total_cnt++;
        if ({frame_done, out_valid, load_ready} !== 3'b101)
            $display("FAIL backpressure_end: got %b expected 101", {frame_done, out_valid, load_ready});
        else pass_cnt++;
        out_ready = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_overrun();
        logic [MW-1:0] m;
        m = mk_mat(1, 1);
        result_in = m; load_valid = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        for (int b = 0; b < 16; b++) begin
            total_cnt++;
            if (obs_beat() !== exp_beat(b + 1, b))
                $display("FAIL overrun_beat%0d: got %h expected %h", b, obs_beat(), exp_beat(b + 1, b));
            else pass_cnt++;
            total_cnt++;
            if (overrun !== (b >= 6))
                $display("FAIL overrun_flag_beat%0d: got %b expected %b", b, overrun, (b >= 6));
            else pass_cnt++;
            load_valid = (b == 5);
            result_in  = (b == 5) ? mk_mat(8'h55, 0) : m;
            @(negedge clock);
        end
        load_valid = 1'b0;
        total_cnt++;
        if ({frame_done, overrun} !== 2'b11)
            $display("FAIL overrun_end: got %b expected 11", {frame_done, overrun});
        else pass_cnt++;
        repeat (3) @(negedge clock);
        total_cnt++;
        if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b expected 1", overrun);
        else pass_cnt++;
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        total_cnt++;
        if (overrun !== 1'b0) $display("FAIL overrun_cleared: got %b expected 0", overrun);
        else pass_cnt++;
    endtask

    task automatic test_clear();
        logic [MW-1:0] m;
        m = mk_mat(1, 1);
        result_in = m; load_valid = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        for (int b = 0; b < 8; b++) begin
            total_cnt++;
            if (obs_beat() !== exp_beat(b + 1, b))
                $display("FAIL clear_beat%0d: got %h expected %h", b, obs_beat(), exp_beat(b + 1, b));
            else pass_cnt++;
            load_valid = (b == 2) || (b == 7);
            clear      = (b == 7);
            result_in  = (b == 7) ? mk_mat(8'hAA, 0) : m;
            @(negedge clock);
        end
        clear = 1'b0; load_valid = 1'b0;
        total_cnt++;
        if ({out_valid, load_ready, overrun, frame_done} !== 4'b0100)
            $display("FAIL clear_next: got %b expected 0100", {out_valid, load_ready, overrun, frame_done});
        else pass_cnt++;
        @(negedge clock);
        total_cnt++;
        if ({out_valid, load_ready} !== 2'b01)
            $display("FAIL clear_load_ignored: got %b expected 01", {out_valid, load_ready});
        else pass_cnt++;
        result_in = mk_mat(8'hAA, 0); load_valid = 1'b1;
        @(negedge clock);
        load_valid = 1'b0;
        for (int b = 0; b < 16; b++) begin
            total_cnt++;
            if (obs_beat() !== exp_beat(8'hAA, b))
                $display("FAIL clear_reload_beat%0d: got %h expected %h", b, obs_beat(), exp_beat(8'hAA, b));
            else pass_cnt++;
            @(negedge clock);
        end
        total_cnt++;
        if ({frame_done, out_valid} !== 2'b10)
            $display("FAIL clear_reload_end: got %b expected 10", {frame_done, out_valid});
        else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        logic [MW-1:0] m;
        m = mk_mat(1, 1);
        result_in = m; load_valid = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        for (int b = 0; b < 4; b++) begin
            total_cnt++;
            if (obs_beat() !== exp_beat(b + 1, b))
                $display("FAIL rst_mid_beat%0d: got %h expected %h", b, obs_beat(), exp_beat(b + 1, b));
            else pass_cnt++;
            load_valid = (b == 1);
            reset      = !(b == 3);
            @(negedge clock);
        end
        reset = 1'b1; load_valid = 1'b0;
        total_cnt++;
        if ({out_valid, out_data, out_row, out_col, out_last, frame_done, overrun, load_ready} !== 16'h0001)
            $display("FAIL rst_mid_values: got %h expected 0001",
                     {out_valid, out_data, out_row, out_col, out_last, frame_done, overrun, load_ready});
        else pass_cnt++;
        @(negedge clock);
        total_cnt++;
        if ({frame_done, out_valid} !== 2'b00)
            $display("FAIL rst_mid_no_done: got %b expected 00", {frame_done, out_valid});
        else pass_cnt++;
        result_in = mk_mat(8'h20, 1); load_valid = 1'b1;
        @(negedge clock);
        load_valid = 1'b0;
        for (int b = 0; b < 16; b++) begin
            total_cnt++;
            if (obs_beat() !== exp_beat(8'h20 + b, b))
                $display("FAIL rst_mid_reload_beat%0d: got %h expected %h", b, obs_beat(), exp_beat(8'h20 + b, b));
            else pass_cnt++;
            @(negedge clock);
        end
        total_cnt++;
        if (frame_done !== 1'b1) $display("FAIL rst_mid_reload_done: got %b expected 1", frame_done);
        else pass_cnt++;
        @(negedge clock);
    endtask

`ifdef MMAC_STREAM_PARITY_EN
    task automatic test_parity();
        logic [MW-1:0] m;
        int            cyc;
        m = mk_mat(0, 0);
        m[MW-1 -: 8] = 8'h07;
        m[MW-9 -: 8] = 8'h03;
        result_in = m; load_valid = 1'b1; out_ready = 1'b1; inject = 1'b0;
        @(negedge clock);
        load_valid = 1'b0;
        total_cnt++;
        if (out_parity !== 1'b1) $display("FAIL parity_07: got %b expected 1", out_parity);
        else pass_cnt++;
        @(negedge clock);
        total_cnt++;
        if (out_parity !== 1'b0) $display("FAIL parity_03: got %b expected 0", out_parity);
        else pass_cnt++;
        repeat (15) @(negedge clock);
        result_in = m; load_valid = 1'b1; inject = 1'b1; out_ready = 1'b0;
        @(negedge clock);
        load_valid = 1'b0; inject = 1'b0;
        total_cnt++;
        if ({out_valid, out_parity} !== 2'b10) $display("FAIL parity_inject: got %b expected 10", {out_valid, out_parity});
        else pass_cnt++;
        repeat (2) @(negedge clock);
        total_cnt++;
        if ({out_data, out_parity} !== 9'h0E) $display("FAIL parity_inject_stall: got %h expected 0e", {out_data, out_parity});
        else pass_cnt++;
        out_ready = 1'b1;
        cyc = 0;
        while (frame_done !== 1'b1 && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        total_cnt++;
        if (frame_done !== 1'b1) $display("FAIL parity_drain_timeout: got %b expected 1", frame_done);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_full_rate();
        test_backpressure();
        test_overrun();
        test_clear();
        test_reset_midstream();
`ifdef MMAC_STREAM_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule

// File: doc/matrix_result_streamer.md
Name: matrix_result_streamer

Overview:
- Drain side of the matrix MAC datapath.
- Captures one packed result matrix (M_SIZE x M_SIZE elements, VAR_WIDTH each) through a load handshake.
- Emits the matrix one element per beat, row-major, on a valid/ready stream with row/column tags and a last marker.
- Sits between the MAC unit's packed result bus and downstream element-wise consumers (writeback, host FIFO).

Parameters:
- M_SIZE, 4, matrix dimension; the matrix holds M_SIZE*M_SIZE elements.
- VAR_WIDTH, 8, bits per element.
- IDX_W, $clog2(M_SIZE), width of the row/column tags.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- clear  in  1  synchronous abort; returns block to IDLE.
- load_valid  in  1  packed result available on result_in.
- load_ready  out  1  block can accept a matrix.
- result_in  in  M_SIZE*M_SIZE*VAR_WIDTH  packed matrix; element e=r*M_SIZE+c at bits [(M_SIZE*M_SIZE-1-e)*VAR_WIDTH +: VAR_WIDTH] (element 0 in MSBs).
- out_valid  out  1  out_* beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  VAR_WIDTH  element value.
- out_row  out  IDX_W  element row.
- out_col  out  IDX_W  element column.
- out_last  out  1  beat is element M_SIZE*M_SIZE-1.
- frame_done  out  1  one-cycle pulse when last beat is accepted.
- overrun  out  1  sticky: load_valid seen while load_ready low.

Behaviour:
- Reset (reset=0 at clock edge):
  - state=IDLE, index=0, capture register=0.
  - out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, frame_done=0, overrun=0.
  - load_ready=1 from the first cycle after reset deasserts.
- Priority: reset > clear > normal operation.
- States:
  - IDLE: load_ready=1, out_valid=0.
  - STREAM: load_ready=0, out_valid=1.
- Load:
  - On load_valid&&load_ready, capture result_in, set index=0, go to STREAM.
  - Element 0 appears on out_* the next cycle, so latency from load to first beat is 1 cycle.
- Beat transfer occurs on out_valid&&out_ready. It increments index; row/col derive from index (col wraps 0..M_SIZE-1, then row increments).
- Stall rule: while out_valid&&!out_ready, out_data/out_row/out_col/out_last hold stable. out_valid never drops without a transfer, except on clear or reset.
- Last beat:
  - out_last=1 exactly when index==M_SIZE*M_SIZE-1.
  - On its transfer: frame_done=1 for the next cycle, state goes to IDLE, index resets to 0.
  - IDLE is held at least one cycle, so a frame costs N+1 cycles at full out_ready (N=M_SIZE*M_SIZE).
- Overrun: load_valid=1 while load_ready=0 sets overrun (sticky) and the load is ignored. The captured matrix and stream are unaffected. Only reset or clear clears overrun.
- Clear:
  - Next cycle: state=IDLE, out_valid=0, index=0, overrun=0, frame_done=0.
  - The capture register keeps its contents.
  - A load_valid in the clear cycle is ignored.
- Reset mid-stream: the stream is abandoned and no frame_done is produced.
- out_ready is ignored in IDLE; load_valid held high in IDLE loads on the first IDLE cycle.

Optional Feature:
- Macro MMAC_STREAM_PARITY_EN.
- Defined:
  - Adds output out_parity (1 bit) = even parity (XOR reduction) of out_data, registered with out_data and stable under stall.
  - Adds input load_parity_err_inject. If high at load, element 0's parity is inverted for test.
- Undefined: neither port exists and there is no parity logic.

Test Plan:
- Reset then load with M_SIZE=4, VAR_WIDTH=8, result_in element e=e+1 (0x01..0x10), out_ready=1:
  - 16 beats on consecutive cycles, out_data 0x01..0x10.
  - row/col (0,0)..(3,3); out_last only on 0x10.
  - frame_done pulses once; load_ready returns 1 the cycle after.
- Same load, out_ready toggles 1,0,0,1,... → every beat delivered exactly once in order, and out_* stay stable during the 0 cycles.
- load_valid pulsed at beat 5 of an active stream → overrun=1, remaining beats still 0x06..0x10 from the original matrix, overrun stays 1 until clear.
- clear asserted at beat 7 → next cycle out_valid=0, load_ready=1, overrun=0. A new load with all elements 0xAA then streams 16×0xAA starting at (0,0).
- reset=0 asserted mid-stream at beat 3 → next cycle all outputs at reset values, no frame_done. A later load streams from element 0.
- With MMAC_STREAM_PARITY_EN: element 0x07 gives out_parity=1, element 0x03 gives out_parity=0; with inject, element 0 shows inverted parity.
